// File: rtl/l2_request_arbiter_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : l2_config_and_types (package)
// Brief   : L2 port configuration, request/write-lock types and helpers
// Revision: 1.0
// ----------------------------------------------------------------------------
package l2_config_and_types;

  localparam int L2_NUM_PORTS = 4;
  localparam int L2_SUB_ID_W  = 2;
  localparam int L2_PORT_W    = $clog2(L2_NUM_PORTS);
  localparam int L2_ID_W      = L2_PORT_W + L2_SUB_ID_W;
  localparam int L2_BEAT_W    = 6;

  typedef struct packed {
    logic                 active;
    logic [L2_PORT_W-1:0] port;
    logic [L2_BEAT_W-1:0] beats_remaining;
  } l2_wr_lock_t;

  typedef struct packed {
    logic [29:0]        addr;
    logic [3:0]         be;
    logic               rnw;
    logic               is_amo;
    logic [4:0]         amo_type_or_burst_size;
    logic [L2_ID_W-1:0] id;
  } l2_mem_req_t;

  // An AMO carries a single operand word; a burst carries length-1 in the field.
  function automatic logic [L2_BEAT_W-1:0] l2_write_beats(input logic       is_amo,
                                                          input logic [4:0] burst_size);
    return is_amo ? L2_BEAT_W'(1) : (L2_BEAT_W'(burst_size) + L2_BEAT_W'(1));
  endfunction

endpackage
`default_nettype wire

// File: rtl/l2_request_arbiter_rr_picker.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : l2_rr_picker
// Brief   : combinational round-robin picker, search starts just after rr_ptr
// Revision: 1.0
// ----------------------------------------------------------------------------
module l2_rr_picker #(
  parameter  int N     = 4,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  int               cand;
  logic [IDX_W-1:0] cand_idx;

  always_comb begin
    gnt      = '0;
    idx      = '0;
    valid    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    // rr_ptr itself is visited last, so the previous winner has lowest priority
    for (int i = 1; i <= N; i++) begin
      cand     = (int'(rr_ptr) + i) % N;
      cand_idx = IDX_W'(cand);
      if (!valid && req[cand_idx]) begin
        valid = 1'b1;
        idx   = cand_idx;
      end
    end
    if (valid) begin
      gnt[idx] = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/l2_request_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : l2_request_arbiter
// Brief   : round-robin L2 request/write-data arbiter with read-return demux
// Revision: 1.0
// ----------------------------------------------------------------------------
module l2_request_arbiter
  import l2_config_and_types::*;
#(
  localparam int NUM_PORTS = L2_NUM_PORTS,
  localparam int SUB_ID_W  = L2_SUB_ID_W,
  localparam int PORT_W    = $clog2(NUM_PORTS),
  localparam int ID_W      = $clog2(NUM_PORTS) + SUB_ID_W
) (
  input  logic                               clk,
  input  logic                               rst,

  input  logic [NUM_PORTS-1:0]               req_valid,
  output logic [NUM_PORTS-1:0]               req_ready,
  input  logic [NUM_PORTS-1:0][29:0]         req_addr,
  input  logic [NUM_PORTS-1:0][3:0]          req_be,
  input  logic [NUM_PORTS-1:0]               req_rnw,
  input  logic [NUM_PORTS-1:0]               req_is_amo,
  input  logic [NUM_PORTS-1:0][4:0]          req_amo_type_or_burst_size,
  input  logic [NUM_PORTS-1:0][SUB_ID_W-1:0] req_sub_id,

  input  logic [NUM_PORTS-1:0][31:0]         wr_data,
  input  logic [NUM_PORTS-1:0]               wr_data_valid,
  output logic [NUM_PORTS-1:0]               wr_data_read,

  output logic [29:0]                        mem_addr,
  output logic [3:0]                         mem_be,
  output logic                               mem_rnw,
  output logic                               mem_is_amo,
  output logic [4:0]                         mem_amo_type_or_burst_size,
  output logic [ID_W-1:0]                    mem_id,
  output logic                               mem_request_valid,
  input  logic                               mem_request_pop,

  output logic [31:0]                        mem_wr_data,
  output logic                               mem_wr_data_valid,
  input  logic                               mem_wr_data_read,

  input  logic [31:0]                        mem_rd_data,
  input  logic [ID_W-1:0]                    mem_rd_id,
  input  logic                               mem_rd_data_valid,
  output logic [31:0]                        rd_data,
  output logic [SUB_ID_W-1:0]                rd_sub_id,
  output logic [NUM_PORTS-1:0]               rd_data_valid
);

  logic                  mem_request_valid_q, mem_request_valid_d;
  l2_mem_req_t           mem_req_q, mem_req_d;
  l2_wr_lock_t           lock_q, lock_d;
  logic [PORT_W-1:0]     rr_ptr_q, rr_ptr_d;

  logic [NUM_PORTS-1:0]  eligible;
  logic [NUM_PORTS-1:0]  pick_gnt;
  logic [PORT_W-1:0]     pick_idx;
  logic                  pick_valid;
  logic                  slot_free;
  logic                  grant;
  logic                  beat_xfer;

  // Reads may overtake an open write burst; only writes wait for the lock.
  always_comb begin
    eligible = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      eligible[p] = req_valid[p] & (req_rnw[p] | ~lock_q.active);
    end
  end

  l2_rr_picker #(
    .N      (NUM_PORTS)
  ) u_rr_picker (
    .req    (eligible),
    .rr_ptr (rr_ptr_q),
    .gnt    (pick_gnt),
    .idx    (pick_idx),
    .valid  (pick_valid)
  );

  assign slot_free = ~mem_request_valid_q | mem_request_pop;
  assign grant     = slot_free & pick_valid;
  assign req_ready = grant ? pick_gnt : '0;

  assign mem_wr_data       = wr_data[lock_q.port];
  assign mem_wr_data_valid = lock_q.active & wr_data_valid[lock_q.port];
  assign beat_xfer         = mem_wr_data_valid & mem_wr_data_read;

  always_comb begin
    wr_data_read = '0;
    if (beat_xfer) begin
      wr_data_read[lock_q.port] = 1'b1;
    end
  end

  always_comb begin
    mem_request_valid_d = mem_request_valid_q;
    mem_req_d           = mem_req_q;
    rr_ptr_d            = rr_ptr_q;
    lock_d              = lock_q;

    if (grant) begin
      mem_request_valid_d              = 1'b1;
      rr_ptr_d                         = pick_idx;
      mem_req_d.addr                   = req_addr[pick_idx];
      mem_req_d.be                     = req_be[pick_idx];
      mem_req_d.rnw                    = req_rnw[pick_idx];
      mem_req_d.is_amo                 = req_is_amo[pick_idx];
      mem_req_d.amo_type_or_burst_size = req_amo_type_or_burst_size[pick_idx];
      mem_req_d.id                     = {pick_idx, req_sub_id[pick_idx]};
    end else if (mem_request_pop) begin
      mem_request_valid_d = 1'b0;
    end

    if (beat_xfer) begin
      if (lock_q.beats_remaining == L2_BEAT_W'(1)) begin
        lock_d = '0;
      end else begin
        lock_d.beats_remaining = lock_q.beats_remaining - L2_BEAT_W'(1);
      end
    end

    // A write is only eligible with no lock open, so this never collides with a beat.
    if (grant && !req_rnw[pick_idx]) begin
      lock_d.active          = 1'b1;
      lock_d.port            = pick_idx;
      lock_d.beats_remaining = l2_write_beats(req_is_amo[pick_idx],
                                              req_amo_type_or_burst_size[pick_idx]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_request_valid_q <= 1'b0;
      mem_req_q           <= '0;
      lock_q              <= '0;
      rr_ptr_q            <= PORT_W'(NUM_PORTS - 1);
    end else begin
      mem_request_valid_q <= mem_request_valid_d;
      mem_req_q           <= mem_req_d;
      lock_q              <= lock_d;
      rr_ptr_q            <= rr_ptr_d;
    end
  end

  assign mem_request_valid          = mem_request_valid_q;
  assign mem_addr                   = mem_req_q.addr;
  assign mem_be                     = mem_req_q.be;
  assign mem_rnw                    = mem_req_q.rnw;
  assign mem_is_amo                 = mem_req_q.is_amo;
  assign mem_amo_type_or_burst_size = mem_req_q.amo_type_or_burst_size;
  assign mem_id                     = mem_req_q.id;

  assign rd_data   = mem_rd_data;
  assign rd_sub_id = mem_rd_id[SUB_ID_W-1:0];

  generate
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_rd_demux
      assign rd_data_valid[p] = mem_rd_data_valid &
                                (mem_rd_id[ID_W-1:SUB_ID_W] == PORT_W'(p));
    end
  endgenerate

endmodule
`default_nettype wire
